proc_top: RTL and testbench
===========================

// Module: proc_top
// PURPOSE
// - Multi-cycle 16-bit processor core with eight GPRs R0..R7, an accumulator A, a result register G and a shared data bus.
// - Fetches one 9-bit instruction from din, then executes it over 2-step (MV/MVI) or 4-step (ADD/SUB) sequences.
// - Driven by a 2-bit step counter; top level of the processor datapath.
// PARAMETERS
// - REG_WIDTH          16  width of din, bus, R0..R7, A, G
// - INSTRUCTION_WIDTH   9  instruction width, IIIXXXYYY
// - COUNTER_WIDTH       2  step counter width, t0..t3
// PORTS
// - clk   in   1                  clock, rising edge
// - rst   in   1                  reset, synchronous, active-low
// - run   in   1                  1 = fetch and execute instructions
// - din   in   REG_WIDTH          instruction word (low 9 bits) at t0; immediate at t1 of MVI
// - bus   out  REG_WIDTH          shared data bus, combinational
// - done  out  1                  1 in the final step of an instruction, combinational
// BEHAVIOUR
// - Instruction fields: cmd = IR[8:6], X = dest = IR[5:3], Y = src = IR[2:0].
// - Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB; 100..111 are NOPs.
// - Reset (rst == 0 at posedge):
//   - R0..R7, A, G and IR clear to 0; step counter t clears to 0.
//   - bus and done then follow the combinational rules below.
// - Step counter t (instance COUNTER, register output t):
//   - On each posedge: if done, t <= 0; else if (t == 0 && !run), hold; else t <= t + 1.
// - t0: bus = 0; done = 0. If run, IR <= din[8:0] at posedge.
// - MV, t1: bus = R[Y]; done = 1; R[X] <= bus.
// - MVI, t1: bus = din (full REG_WIDTH); done = 1; R[X] <= bus.
// - ADD/SUB, t1: bus = R[X]; A <= bus.
// - ADD/SUB, t2: bus = R[Y]; G <= A + bus (ADD) or A - bus (SUB).
//   - Arithmetic is modulo 2^REG_WIDTH; no carry or flags.
// - ADD/SUB, t3: bus = G; done = 1; R[X] <= G.
// - NOP, t1: bus = 0; done = 1; no register writes.
// - Bus mux is one-hot, priority-free: exactly one source per step; 0 when none selected.
// - Register writes take effect at the posedge ending the step, so the new value is visible from the next instruction.
// - X == Y is legal:
//   - MV Rx,Rx is a no-op write.
//   - ADD Rx,Rx doubles Rx.
//   - SUB Rx,Rx yields 0.
// - run deasserted mid-instruction: the instruction still completes. Only the next fetch waits in t0.
// - Reset mid-instruction: the sequence aborts, t returns to 0, and all registers clear.
// STRUCTURE
// - Shared package proc_pkg holds:
//   - opcode localparams OP_MV/OP_MVI/OP_ADD/OP_SUB;
//   - field-position constants;
//   - default widths.
// - Sub-module step_counter (params COUNTER_WIDTH), instantiated as COUNTER.
//   - Inputs: clk, rst, run, done; output reg t.
// - Hierarchical path COUNTER.t must exist: benches probe and force it.
// - Rest of top: IR, register file, A, G, ALU, combinational control decode and bus mux.
// TESTING
// - MVI R0,#0005 then MV R1,R0 -> bus = 0005 with done = 1 at t1 of each; R1 = 0005.
// - MVI R2,#00A5; MV R3,R2 -> bus = 00A5 at MV t1; t returns to 0 after each done.
// - MVI R4,#0005; MVI R5,#0003; ADD R4,R5 -> bus = 0008, done at t3. Then SUB R4,R5 -> bus = 0005 at t3.
// - MVI R6,#00C3; MV R7,R6; ADD R6,R7 -> 0186. Then SUB R7,R6 -> FF3D (wrap-around).
// - run = 0 in t0 -> t holds 0, no register changes. rst = 0 during ADD t2 -> t = 0, all regs 0 next cycle.
// - NOP opcode 101 -> done = 1 at t1, bus = 0, all registers unchanged.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Brief    : Shared opcodes, instruction field positions and default widths.
//  Revision : 1.0
// ============================================================================
package proc_pkg;

    localparam int DEF_REG_WIDTH         = 16;
    localparam int DEF_INSTRUCTION_WIDTH = 9;
    localparam int DEF_COUNTER_WIDTH     = 2;

    localparam int NUM_GPR       = 8;
    localparam int GPR_SEL_WIDTH = 3;

    // Instruction layout IIIXXXYYY
    localparam int IR_CMD_MSB = 8;
    localparam int IR_CMD_LSB = 6;
    localparam int IR_X_MSB   = 5;
    localparam int IR_X_LSB   = 3;
    localparam int IR_Y_MSB   = 2;
    localparam int IR_Y_LSB   = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd == OP_ADD) || (cmd == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_counter.sv
`default_nettype none
// ============================================================================
//  Module   : step_counter
//  Brief    : Instruction step counter; waits in step 0 until run is high.
//  Revision : 1.0
// ============================================================================
module step_counter #(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     done,
    output logic [COUNTER_WIDTH-1:0] t
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            t <= '0;
        end else if (done) begin
            t <= '0;
        end else if ((t == '0) && !run) begin
            t <= t;
        end else begin
            t <= t + COUNTER_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/proc_top.sv
`default_nettype none
// ============================================================================
//  Module   : proc_top
//  Brief    : Multi-cycle 16-bit processor core: GPRs, A, G, ALU, bus mux.
//  Revision : 1.0
// ============================================================================
module proc_top
    import proc_pkg::*;
#(
    parameter int REG_WIDTH         = DEF_REG_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int COUNTER_WIDTH     = DEF_COUNTER_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [REG_WIDTH-1:0] din,
    output logic [REG_WIDTH-1:0] bus,
    output logic                 done
);

    localparam logic [COUNTER_WIDTH-1:0] c_T0 = COUNTER_WIDTH'(0);
    localparam logic [COUNTER_WIDTH-1:0] c_T1 = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] c_T2 = COUNTER_WIDTH'(2);
    localparam logic [COUNTER_WIDTH-1:0] c_T3 = COUNTER_WIDTH'(3);

    logic [COUNTER_WIDTH-1:0]     t;
    logic [INSTRUCTION_WIDTH-1:0] r_ir;
    logic [REG_WIDTH-1:0]         r_gpr [NUM_GPR];
    logic [REG_WIDTH-1:0]         r_a;
    logic [REG_WIDTH-1:0]         r_g;

    logic [2:0]               w_cmd;
    logic [GPR_SEL_WIDTH-1:0] w_x;
    logic [GPR_SEL_WIDTH-1:0] w_y;
    logic [NUM_GPR-1:0]       w_sel_r;
    logic                     w_sel_din;
    logic                     w_sel_g;
    logic                     w_done;
    logic                     w_ir_wen;
    logic                     w_rx_wen;
    logic                     w_a_wen;
    logic                     w_g_wen;
    logic [REG_WIDTH-1:0]     w_bus;
    logic [REG_WIDTH-1:0]     w_alu;

    step_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) COUNTER (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .done (w_done),
        .t    (t)
    );

    assign w_cmd = r_ir[IR_CMD_MSB:IR_CMD_LSB];
    assign w_x   = r_ir[IR_X_MSB:IR_X_LSB];
    assign w_y   = r_ir[IR_Y_MSB:IR_Y_LSB];

    always_comb begin
        w_sel_r   = '0;
        w_sel_din = 1'b0;
        w_sel_g   = 1'b0;
        w_done    = 1'b0;
        w_ir_wen  = 1'b0;
        w_rx_wen  = 1'b0;
        w_a_wen   = 1'b0;
        w_g_wen   = 1'b0;
        case (t)
            c_T0: w_ir_wen = run;
            c_T1: begin
                case (w_cmd)
                    OP_MV: begin
                        w_sel_r[w_y] = 1'b1;
                        w_rx_wen     = 1'b1;
                        w_done       = 1'b1;
                    end
                    OP_MVI: begin
                        w_sel_din = 1'b1;
                        w_rx_wen  = 1'b1;
                        w_done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_sel_r[w_x] = 1'b1;
                        w_a_wen      = 1'b1;
                    end
                    default: w_done = 1'b1;
                endcase
            end
            c_T2: begin
                if (is_arith(w_cmd)) begin
                    w_sel_r[w_y] = 1'b1;
                    w_g_wen      = 1'b1;
                end
            end
            c_T3: begin
                if (is_arith(w_cmd)) begin
                    w_sel_g  = 1'b1;
                    w_rx_wen = 1'b1;
                    w_done   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // AND-OR mux: selects are one-hot, so no priority is needed
    always_comb begin
        w_bus = ({REG_WIDTH{w_sel_din}} & din) | ({REG_WIDTH{w_sel_g}} & r_g);
        for (int i = 0; i < NUM_GPR; i++) begin
            w_bus = w_bus | ({REG_WIDTH{w_sel_r[i]}} & r_gpr[i]);
        end
    end

    assign w_alu = (w_cmd == OP_SUB) ? (r_a - w_bus) : (r_a + w_bus);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ir <= '0;
            r_a  <= '0;
            r_g  <= '0;
            for (int i = 0; i < NUM_GPR; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            if (w_ir_wen) r_ir <= din[INSTRUCTION_WIDTH-1:0];
            if (w_a_wen)  r_a  <= w_bus;
            if (w_g_wen)  r_g  <= w_alu;
            if (w_rx_wen) r_gpr[w_x] <= w_bus;
        end
    end

    assign bus  = w_bus;
    assign done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_proc_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_top
//  Brief    : Self-checking bench for proc_top against an instruction-level model.
//  Revision : 1.0
// ============================================================================
module tb_proc_top;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic [15:0] bus;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: register contents only, updated once per instruction
    logic [15:0] m [8];

    proc_top #(
        .REG_WIDTH         (16),
        .INSTRUCTION_WIDTH (9),
        .COUNTER_WIDTH     (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .din  (din),
        .bus  (bus),
        .done (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Executes one instruction, checking t, bus and done at every step
    task automatic run_instr(input logic [2:0] cmd, input logic [2:0] x,
                             input logic [2:0] y, input logic [15:0] imm);
        logic [15:0] eb [4];
        logic [15:0] res;
        int          n;
        n     = 2;
        eb[0] = 16'h0000;
        eb[1] = 16'h0000;
        eb[2] = 16'h0000;
        eb[3] = 16'h0000;
        res   = 16'h0000;
        case (cmd)
            3'd0: begin res = m[y]; eb[1] = res; end
            3'd1: begin res = imm;  eb[1] = res; end
            3'd2: begin n = 4; eb[1] = m[x]; eb[2] = m[y]; res = m[x] + m[y]; eb[3] = res; end
            3'd3: begin n = 4; eb[1] = m[x]; eb[2] = m[y]; res = m[x] - m[y]; eb[3] = res; end
            default: ;
        endcase
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            if (s == 0) begin
                din      = 16'($urandom);
                din[8:0] = {cmd, x, y};
                run      = 1'b1;
            end else if (s == 1 && cmd == 3'd1) begin
                din = imm;
                run = 1'($urandom_range(0, 1));
            end else begin
                din = 16'($urandom);
                run = 1'($urandom_range(0, 1));
            end
            #1;
            n_tests++;
            if (dut.COUNTER.t !== 2'(s)) begin
                n_fail++;
                $display("FAIL step_t op=%0d step=%0d: got %0d, expected %0d", cmd, s, dut.COUNTER.t, s);
            end
            n_tests++;
            if (bus !== eb[s]) begin
                n_fail++;
                $display("FAIL bus op=%0d x=%0d y=%0d step=%0d: got %h, expected %h", cmd, x, y, s, bus, eb[s]);
            end
            n_tests++;
            if (done !== (s == n - 1)) begin
                n_fail++;
                $display("FAIL done op=%0d step=%0d: got %b, expected %b", cmd, s, done, (s == n - 1));
            end
        end
        @(negedge clk);
        run = 1'b0;
        din = 16'h0000;
        if (cmd < 3'd4) m[x] = res;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        run = 1'b1;
        din = 16'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (dut.COUNTER.t !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_t: got %0d, expected 0", dut.COUNTER.t);
        end
        n_tests++;
        if (bus !== 16'h0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bus=%h done=%b, expected bus=0000 done=0", bus, done);
        end
        n_tests++;
        if (dut.r_a !== 16'h0000 || dut.r_g !== 16'h0000 || dut.r_ir !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_aux: got A=%h G=%h IR=%h, expected all 0", dut.r_a, dut.r_g, dut.r_ir);
        end
        for (int i = 0; i < 8; i++) begin
            m[i] = 16'h0000;
            n_tests++;
            if (dut.r_gpr[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_R%0d: got %h, expected 0000", i, dut.r_gpr[i]);
            end
        end
        rst = 1'b1;
        run = 1'b0;
    endtask

    task automatic test_mv_mvi;
        run_instr(3'd1, 3'd0, 3'd0, 16'h0005);
        run_instr(3'd0, 3'd1, 3'd0, 16'h0000);
        run_instr(3'd1, 3'd2, 3'd0, 16'h00A5);
        run_instr(3'd0, 3'd3, 3'd2, 16'h0000);
        run_instr(3'd0, 3'd3, 3'd3, 16'h0000);
        n_tests++;
        if (dut.r_gpr[1] !== 16'h0005 || dut.r_gpr[3] !== 16'h00A5) begin
            n_fail++;
            $display("FAIL mv_result: got R1=%h R3=%h, expected 0005 00A5", dut.r_gpr[1], dut.r_gpr[3]);
        end
    endtask

    task automatic test_add_sub;
        run_instr(3'd1, 3'd4, 3'd0, 16'h0005);
        run_instr(3'd1, 3'd5, 3'd0, 16'h0003);
        run_instr(3'd2, 3'd4, 3'd5, 16'h0000);
        n_tests++;
        if (dut.r_gpr[4] !== 16'h0008) begin
            n_fail++;
            $display("FAIL add_result: got %h, expected 0008", dut.r_gpr[4]);
        end
        run_instr(3'd3, 3'd4, 3'd5, 16'h0000);
        n_tests++;
        if (dut.r_gpr[4] !== 16'h0005) begin
            n_fail++;
            $display("FAIL sub_result: got %h, expected 0005", dut.r_gpr[4]);
        end
        run_instr(3'd1, 3'd6, 3'd0, 16'h00C3);
        run_instr(3'd0, 3'd7, 3'd6, 16'h0000);
        run_instr(3'd2, 3'd6, 3'd7, 16'h0000);
        run_instr(3'd3, 3'd7, 3'd6, 16'h0000);
        n_tests++;
        if (dut.r_gpr[6] !== 16'h0186 || dut.r_gpr[7] !== 16'hFF3D) begin
            n_fail++;
            $display("FAIL wrap_result: got R6=%h R7=%h, expected 0186 FF3D", dut.r_gpr[6], dut.r_gpr[7]);
        end
        run_instr(3'd2, 3'd1, 3'd1, 16'h0000);
        run_instr(3'd3, 3'd2, 3'd2, 16'h0000);
        n_tests++;
        if (dut.r_gpr[1] !== 16'h000A || dut.r_gpr[2] !== 16'h0000) begin
            n_fail++;
            $display("FAIL same_reg: got R1=%h R2=%h, expected 000A 0000", dut.r_gpr[1], dut.r_gpr[2]);
        end
    endtask

    task automatic test_run_hold;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            run = 1'b0;
            din = 16'($urandom);
            #1;
            n_tests++;
            if (dut.COUNTER.t !== 2'd0 || bus !== 16'h0000 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL run_hold: got t=%0d bus=%h done=%b, expected t=0 bus=0000 done=0",
                         dut.COUNTER.t, bus, done);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (dut.r_gpr[i] !== m[i]) begin
                n_fail++;
                $display("FAIL run_hold_R%0d: got %h, expected %h", i, dut.r_gpr[i], m[i]);
            end
        end
    endtask

    task automatic test_nop;
        run_instr(3'd5, 3'($urandom), 3'($urandom), 16'($urandom));
        run_instr(3'd7, 3'($urandom), 3'($urandom), 16'($urandom));
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (dut.r_gpr[i] !== m[i]) begin
                n_fail++;
                $display("FAIL nop_R%0d: got %h, expected %h", i, dut.r_gpr[i], m[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        run_instr(3'd1, 3'd4, 3'd0, 16'h1234);
        @(negedge clk);
        din      = 16'h0000;
        din[8:0] = {3'd2, 3'd4, 3'd4};
        run      = 1'b1;
        @(negedge clk);
        din = 16'($urandom);
        @(negedge clk);
        n_tests++;
        if (dut.COUNTER.t !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got t=%0d, expected 2", dut.COUNTER.t);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (dut.COUNTER.t !== 2'd0 || bus !== 16'h0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: got t=%0d bus=%h done=%b, expected 0 0000 0", dut.COUNTER.t, bus, done);
        end
        n_tests++;
        if (dut.r_a !== 16'h0000 || dut.r_g !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_aux: got A=%h G=%h, expected 0000 0000", dut.r_a, dut.r_g);
        end
        for (int i = 0; i < 8; i++) begin
            m[i] = 16'h0000;
            n_tests++;
            if (dut.r_gpr[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_mid_R%0d: got %h, expected 0000", i, dut.r_gpr[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            run_instr(3'd1, 3'(k), 3'd0, 16'($urandom));
        end
        for (int k = 0; k < 150; k++) begin
            run_instr(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                din = 16'($urandom);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (dut.r_gpr[i] !== m[i]) begin
                n_fail++;
                $display("FAIL random_R%0d: got %h, expected %h", i, dut.r_gpr[i], m[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        din = 16'h0000;
        test_reset;
        test_mv_mvi;
        test_add_sub;
        test_run_hold;
        test_nop;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
